// File: rtl/register_scoreboard_pkg.sv
// Shared widths and types for the register scoreboard: register index width and
// pending-write counter width derived from the default configuration.
package register_scoreboard_pkg;

    localparam int DEFAULT_NUM_REGS     = 32;
    localparam int DEFAULT_MAX_INFLIGHT = 3;

    function automatic int reg_idx_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    function automatic int sb_cnt_w(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    localparam int REG_IDX_W = reg_idx_w(DEFAULT_NUM_REGS);
    localparam int SB_CNT_W  = sb_cnt_w(DEFAULT_MAX_INFLIGHT);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [SB_CNT_W-1:0]  scoreboard_cnt_t;

endpackage

// File: rtl/register_scoreboard_sb_counter.sv
// One saturating up/down counter. Inc and dec in the same cycle cancel; a
// decrement at zero is dropped and flagged on underflow_o for that cycle.
module sb_counter
    import register_scoreboard_pkg::*;
#(
    parameter int MAX_VAL = DEFAULT_MAX_INFLIGHT,
    parameter int CNT_W   = sb_cnt_w(MAX_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_ok;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = dec_i & (cnt_q == '0);
        dec_ok      = dec_i & ~underflow_o;
        case ({inc_i, dec_ok})
            2'b10: if (cnt_q != CNT_W'(MAX_VAL)) cnt_d = cnt_q + CNT_W'(1);
            2'b01: cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/register_scoreboard.sv
// Per-register pending-write scoreboard gating decode->execute issue; stalls on
// pending loads (FORWARDING=1) or on any pending write (FORWARDING=0).
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int NUM_REGS       = DEFAULT_NUM_REGS,
    parameter int NUM_READ_PORTS = 2,
    parameter int MAX_INFLIGHT   = DEFAULT_MAX_INFLIGHT,
    parameter int FORWARDING     = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        issue_valid,
    output logic                                        issue_ready,
    input  logic [$clog2(NUM_REGS)-1:0]                 issue_rd,
    input  logic                                        issue_rd_we,
    input  logic                                        issue_is_load,
    input  logic [NUM_READ_PORTS*$clog2(NUM_REGS)-1:0]  issue_rs,
    input  logic [NUM_READ_PORTS-1:0]                   issue_rs_used,
    input  logic                                        load_done_valid,
    input  logic [$clog2(NUM_REGS)-1:0]                 load_done_rd,
    input  logic                                        retire_valid,
    input  logic [$clog2(NUM_REGS)-1:0]                 retire_rd,
    output logic [NUM_REGS-1:0]                         busy,
    output logic                                        stall_raw,
    output logic                                        stall_waw,
    output logic                                        underflow_err
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = sb_cnt_w(MAX_INFLIGHT);

    logic [NUM_REGS-1:0] pend_nz;
    logic [NUM_REGS-1:0] lpend_nz;
    logic [NUM_REGS-1:0] pend_full;
    logic [NUM_REGS-1:0] uf_vec;
    logic                raw_hazard;
    logic                waw_sat;
    logic                issue_fire;
    logic [IDX_W-1:0]    rs_idx;
    logic                underflow_err_q;
    logic                underflow_err_d;

    // Hazards look only at registered counts; same-cycle drains take effect next cycle.
    always_comb begin
        raw_hazard = 1'b0;
        rs_idx     = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rs_idx = issue_rs[p*IDX_W +: IDX_W];
            if (issue_rs_used[p] && (rs_idx != '0)) begin
                if (FORWARDING != 0) raw_hazard = raw_hazard | lpend_nz[rs_idx];
                else                 raw_hazard = raw_hazard | pend_nz[rs_idx];
            end
        end
    end

    assign waw_sat     = issue_rd_we & (issue_rd != '0) & pend_full[issue_rd];
    assign issue_ready = ~raw_hazard & ~waw_sat;
    assign stall_raw   = issue_valid & raw_hazard;
    assign stall_waw   = issue_valid & waw_sat;
    assign issue_fire  = issue_valid & issue_ready & issue_rd_we & (issue_rd != '0);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign pend_nz[r]   = 1'b0;
            assign lpend_nz[r]  = 1'b0;
            assign pend_full[r] = 1'b0;
            assign uf_vec[r]    = 1'b0;
        end else begin : g_track
            logic [CNT_W-1:0] pend_cnt;
            logic [CNT_W-1:0] lpend_cnt;
            logic             pend_uf;
            logic             lpend_uf;
            logic             hit_issue;
            logic             hit_retire;
            logic             hit_load;

            assign hit_issue  = issue_fire & (issue_rd == IDX_W'(r));
            assign hit_retire = retire_valid & (retire_rd == IDX_W'(r));
            assign hit_load   = load_done_valid & (load_done_rd == IDX_W'(r));

            sb_counter #(.MAX_VAL(MAX_INFLIGHT), .CNT_W(CNT_W)) u_pend (
                .clk        (clk),
                .rst_n      (rst),
                .inc_i      (hit_issue),
                .dec_i      (hit_retire),
                .cnt_o      (pend_cnt),
                .underflow_o(pend_uf)
            );

            sb_counter #(.MAX_VAL(MAX_INFLIGHT), .CNT_W(CNT_W)) u_lpend (
                .clk        (clk),
                .rst_n      (rst),
                .inc_i      (hit_issue & issue_is_load),
                .dec_i      (hit_load),
                .cnt_o      (lpend_cnt),
                .underflow_o(lpend_uf)
            );

            assign pend_nz[r]   = |pend_cnt;
            assign lpend_nz[r]  = |lpend_cnt;
            assign pend_full[r] = (pend_cnt == CNT_W'(MAX_INFLIGHT));
            assign uf_vec[r]    = pend_uf | lpend_uf;
        end
    end

    assign underflow_err_d = underflow_err_q | (|uf_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) underflow_err_q <= 1'b0;
        else      underflow_err_q <= underflow_err_d;
    end

    assign underflow_err = underflow_err_q;
    assign busy          = pend_nz;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench: instance A forwards (stalls on loads only), instance B stalls
// on any pending write. Issue fields are shared; valids are per instance.
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv_a, iv_b, lv_a, lv_b, rv_a, rv_b;
    logic [4:0]  issue_rd, ld_rd, ret_rd;
    logic        we, is_load;
    logic [9:0]  rs;
    logic [1:0]  used;

    logic        ready_a, raw_a, waw_a, err_a;
    logic        ready_b, raw_b, waw_b, err_b;
    logic [31:0] busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_scoreboard #(.NUM_REGS(32), .NUM_READ_PORTS(2), .MAX_INFLIGHT(3), .FORWARDING(1)) u_a (
        .clk(clk), .rst(rst), .issue_valid(iv_a), .issue_ready(ready_a),
        .issue_rd(issue_rd), .issue_rd_we(we), .issue_is_load(is_load),
        .issue_rs(rs), .issue_rs_used(used),
        .load_done_valid(lv_a), .load_done_rd(ld_rd),
        .retire_valid(rv_a), .retire_rd(ret_rd),
        .busy(busy_a), .stall_raw(raw_a), .stall_waw(waw_a), .underflow_err(err_a)
    );

    register_scoreboard #(.NUM_REGS(32), .NUM_READ_PORTS(2), .MAX_INFLIGHT(3), .FORWARDING(0)) u_b (
        .clk(clk), .rst(rst), .issue_valid(iv_b), .issue_ready(ready_b),
        .issue_rd(issue_rd), .issue_rd_we(we), .issue_is_load(is_load),
        .issue_rs(rs), .issue_rs_used(used),
        .load_done_valid(lv_b), .load_done_rd(ld_rd),
        .retire_valid(rv_b), .retire_rd(ret_rd),
        .busy(busy_b), .stall_raw(raw_b), .stall_waw(waw_b), .underflow_err(err_b)
    );

    function automatic logic [31:0] bit_of(input int n);
        return 32'h1 << n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        {iv_a, iv_b, lv_a, lv_b, rv_a, rv_b} = '0;
        issue_rd = '0; ld_rd = '0; ret_rd = '0;
        we = 1'b0; is_load = 1'b0; rs = '0; used = '0;
        #2;
        chk("reset_busy_a", busy_a, 32'h0);
        chk("reset_busy_b", busy_b, 32'h0);
        chk("reset_err_a", {31'h0, err_a}, 32'h0);
        chk("reset_ready_a", {31'h0, ready_a}, 32'h1);
        step();
        rst = 1'b1;

        // Load-use hazard with forwarding
        iv_a = 1'b1; issue_rd = 5'd5; we = 1'b1; is_load = 1'b1; used = 2'b00;
        settle();
        chk("t1_load_ready", {31'h0, ready_a}, 32'h1);
        step();
        we = 1'b0; is_load = 1'b0; rs = {5'd0, 5'd5}; used = 2'b01;
        settle();
        chk("t1_busy5", busy_a, bit_of(5));
        chk("t1_use_ready", {31'h0, ready_a}, 32'h0);
        chk("t1_stall_raw", {31'h0, raw_a}, 32'h1);
        chk("t1_stall_waw", {31'h0, waw_a}, 32'h0);
        lv_a = 1'b1; ld_rd = 5'd5;
        settle();
        chk("t1_no_bypass", {31'h0, ready_a}, 32'h0);
        step();
        lv_a = 1'b0;
        settle();
        chk("t1_ready_after_ld", {31'h0, ready_a}, 32'h1);
        chk("t1_raw_clear", {31'h0, raw_a}, 32'h0);
        chk("t1_busy5_held", busy_a, bit_of(5));
        step();
        iv_a = 1'b0; rv_a = 1'b1; ret_rd = 5'd5;
        step();
        rv_a = 1'b0;
        settle();
        chk("t1_busy_drained", busy_a, 32'h0);

        // Non-load producer does not stall the forwarding instance
        iv_a = 1'b1; issue_rd = 5'd8; we = 1'b1; is_load = 1'b0; used = 2'b00;
        step();
        we = 1'b0; rs = {5'd0, 5'd8}; used = 2'b01;
        settle();
        chk("t1b_fwd_ready", {31'h0, ready_a}, 32'h1);
        chk("t1b_busy8", busy_a, bit_of(8));
        iv_a = 1'b0; rv_a = 1'b1; ret_rd = 5'd8;
        step();
        rv_a = 1'b0;

        // No forwarding: stall until writeback
        iv_b = 1'b1; issue_rd = 5'd3; we = 1'b1; is_load = 1'b0; used = 2'b00;
        settle();
        chk("t2_prod_ready", {31'h0, ready_b}, 32'h1);
        step();
        we = 1'b0; rs = {5'd3, 5'd0}; used = 2'b10;
        settle();
        chk("t2_use_ready", {31'h0, ready_b}, 32'h0);
        chk("t2_stall_raw", {31'h0, raw_b}, 32'h1);
        chk("t2_busy3", busy_b, bit_of(3));
        step();
        chk("t2_still_stalled", {31'h0, ready_b}, 32'h0);
        rv_b = 1'b1; ret_rd = 5'd3;
        settle();
        chk("t2_no_bypass", {31'h0, ready_b}, 32'h0);
        step();
        rv_b = 1'b0;
        settle();
        chk("t2_ready_after_ret", {31'h0, ready_b}, 32'h1);
        chk("t2_busy3_clear", busy_b, 32'h0);
        step();
        iv_b = 1'b0;

        // Saturation at MAX_INFLIGHT
        iv_a = 1'b1; issue_rd = 5'd7; we = 1'b1; is_load = 1'b0; used = 2'b00;
        step();
        step();
        step();
        chk("t3_full_ready", {31'h0, ready_a}, 32'h0);
        chk("t3_stall_waw", {31'h0, waw_a}, 32'h1);
        chk("t3_stall_raw", {31'h0, raw_a}, 32'h0);
        chk("t3_busy7", busy_a, bit_of(7));
        rv_a = 1'b1; ret_rd = 5'd7;
        settle();
        chk("t3_no_bypass", {31'h0, ready_a}, 32'h0);
        step();
        rv_a = 1'b0;
        settle();
        chk("t3_ready_after_ret", {31'h0, ready_a}, 32'h1);
        chk("t3_waw_clear", {31'h0, waw_a}, 32'h0);
        step();
        iv_a = 1'b0;
        settle();
        chk("t3_full_again", {31'h0, waw_a | ready_a}, 32'h0);
        rv_a = 1'b1;
        step();
        step();
        step();
        rv_a = 1'b0;
        settle();
        chk("t3_drained", busy_a, 32'h0);
        chk("t3_no_err", {31'h0, err_a}, 32'h0);

        // Same-cycle issue and retire on one register
        iv_a = 1'b1; issue_rd = 5'd9; we = 1'b1;
        step();
        rv_a = 1'b1; ret_rd = 5'd9;
        settle();
        chk("t4_ready", {31'h0, ready_a}, 32'h1);
        step();
        iv_a = 1'b0; rv_a = 1'b0;
        settle();
        chk("t4_busy9_net", busy_a, bit_of(9));
        rv_a = 1'b1;
        step();
        rv_a = 1'b0;
        settle();
        chk("t4_busy9_clear", busy_a, 32'h0);
        chk("t4_no_err", {31'h0, err_a}, 32'h0);

        // Register 0 is never tracked
        iv_a = 1'b1; issue_rd = 5'd0; we = 1'b1; is_load = 1'b1; rs = 10'd0; used = 2'b11;
        settle();
        chk("t5_ready", {31'h0, ready_a}, 32'h1);
        chk("t5_raw", {31'h0, raw_a}, 32'h0);
        chk("t5_waw", {31'h0, waw_a}, 32'h0);
        step();
        step();
        iv_a = 1'b0; is_load = 1'b0; used = 2'b00;
        rv_a = 1'b1; ret_rd = 5'd0; lv_a = 1'b1; ld_rd = 5'd0;
        step();
        rv_a = 1'b0; lv_a = 1'b0;
        settle();
        chk("t5_busy", busy_a, 32'h0);
        chk("t5_no_err", {31'h0, err_a}, 32'h0);

        // Underflow is sticky; asynchronous reset clears it
        rv_a = 1'b1; ret_rd = 5'd4; lv_b = 1'b1; ld_rd = 5'd4;
        settle();
        chk("t6_err_registered", {31'h0, err_a}, 32'h0);
        step();
        rv_a = 1'b0; lv_b = 1'b0;
        settle();
        chk("t6_err_a", {31'h0, err_a}, 32'h1);
        chk("t6_err_b", {31'h0, err_b}, 32'h1);
        chk("t6_counts_unchanged", busy_a, 32'h0);
        iv_a = 1'b1; issue_rd = 5'd10; we = 1'b1;
        step();
        iv_a = 1'b0; we = 1'b0;
        settle();
        chk("t6_busy10", busy_a, bit_of(10));
        chk("t6_err_sticky", {31'h0, err_a}, 32'h1);
        rst = 1'b0;
        #1;
        chk("t6_async_busy", busy_a, 32'h0);
        chk("t6_async_err_a", {31'h0, err_a}, 32'h0);
        chk("t6_async_err_b", {31'h0, err_b}, 32'h0);
        step();
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
Parametrised hazard-tracking block for the in-order pipeline. It replaces ad-hoc stall logic with a per-register pending-write scoreboard and generalises to N read ports, configurable in-flight depth, and two modes:
- FORWARDING=1 stalls only on load-use hazards.
- FORWARDING=0 stalls until writeback.

It sits between decode and execute and gates the decode→execute handshake.

Parameters:
NUM_REGS, 32, architectural registers; register 0 is never tracked.
NUM_READ_PORTS, 2, source operands checked per issue.
MAX_INFLIGHT, 3, max outstanding writes per register; CNT_W = $clog2(MAX_INFLIGHT+1).
FORWARDING, 1, 1 = stall on pending load only; 0 = stall on any pending write.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
issue_valid  in  1  decode presents an instruction
issue_ready  out  1  instruction may issue this cycle (combinational)
issue_rd  in  $clog2(NUM_REGS)  destination register
issue_rd_we  in  1  instruction writes issue_rd
issue_is_load  in  1  result becomes available only at load completion
issue_rs  in  NUM_READ_PORTS*$clog2(NUM_REGS)  source registers, packed
issue_rs_used  in  NUM_READ_PORTS  per-port use mask
load_done_valid  in  1  load data available for forwarding (end of memory stage)
load_done_rd  in  $clog2(NUM_REGS)  register of that load
retire_valid  in  1  writeback stage retires a tracked write
retire_rd  in  $clog2(NUM_REGS)  register retired
busy  out  NUM_REGS  bit r = pending write count of r is non-zero
stall_raw  out  1  issue_valid & blocked by a source hazard
stall_waw  out  1  issue_valid & blocked by count saturation
underflow_err  out  1  sticky: retire or load_done with zero count

Behaviour:
- State per register r ≥ 1:
  - pend[r] (CNT_W bits): outstanding writes.
  - lpend[r] (CNT_W bits): outstanding loads whose data has not yet reached load_done.
- Reset (rst=0, asynchronous): all pend/lpend = 0; underflow_err = 0; busy = 0.
  - issue_ready then reflects inputs combinationally.
  - In-flight instructions are lost; a reset mid-operation requires a pipeline reset.
- Issue fires when issue_valid & issue_ready. Fire with issue_rd_we & issue_rd≠0:
  - pend[rd] += 1.
  - If issue_is_load, lpend[rd] += 1 as well.
- Hazard for port p (issue_rs_used[p] & rs_p≠0):
  - FORWARDING=1: hazard when lpend[rs_p] ≠ 0.
  - FORWARDING=0: hazard when pend[rs_p] ≠ 0.
- stall_raw = issue_valid & any port hazard.
- stall_waw = issue_valid & issue_rd_we & rd≠0 & pend[rd] == MAX_INFLIGHT.
- issue_ready = ~(any hazard) & ~(saturation), evaluated on the current-cycle state only. No bypass of a same-cycle retire or load_done; the effect is one cycle later.
- load_done_valid, rd≠0: lpend[rd] -= 1. If lpend is already 0, there is no change and underflow_err is set.
- retire_valid, rd≠0: pend[rd] -= 1. If pend is already 0, there is no change and underflow_err is set.
- Simultaneous events on one register are applied as a single net update in one cycle (issue +1, retire −1, load_done −1 on lpend).
  - Example: pend=1, issue and retire same rd → pend stays 1.
- Register 0 is ignored on all ports; busy[0] = 0 always.
- Flush contract: squashed instructions are not removed here. Downstream stages carry them as bubbles and still assert retire_valid (and load_done_valid for loads), so counts always drain.
- Latency: state updates visible on the cycle after the event; issue_ready is combinational from state plus issue inputs.
- underflow_err clears only on reset.

Decomposition:
- Package common: REGISTER_DEPTH-derived index width, and scoreboard_cnt_t sized by MAX_INFLIGHT.
- Sub-module sb_counter: one saturating up/down counter with inc, dec, and an underflow flag.
  - Instantiated twice per register in a generate loop.
- The top-level handles port unpacking, hazard reduction and error OR-reduction.

Test Plan:
1. Reset, FORWARDING=1: issue load x5, then issue add rs1=x5 → issue_ready=0, stall_raw=1. Pulse load_done_rd=5; next cycle issue_ready=1, busy[5] stays 1 until retire_rd=5.
2. FORWARDING=0: issue add rd=x3, then use rs2=x3 → stalled until retire_rd=3. Ready on the following cycle; busy[3]=0.
3. MAX_INFLIGHT=3: three writes to x7 without retire → pend=3. Fourth issue shows stall_waw=1. One retire_rd=7 → fourth issue accepted next cycle.
4. Same-cycle issue rd=x9 and retire rd=x9 with pend=1 → pend remains 1, busy[9]=1. A second retire → busy[9]=0.
5. Issue rd=x0 and rs=x0 with issue_is_load → never stalls; busy=0; retire_rd=0 does not set underflow_err.
6. retire_rd=4 with pend[4]=0 → underflow_err=1, counts unchanged. Assert rst=0 mid-cycle → err and all busy clear immediately (asynchronous).
